// File: rtl/sensor_cmd_router.sv
// UART-facing command router: one ASCII byte selects a sensor channel, whose result
// is returned as NDIG decimal ASCII digits plus CR over a valid/ready TX stream.
`timescale 1ns/1ps
module sensor_cmd_router #(
    parameter int N_CH        = 4,
    parameter int DATA_W      = 16,
    parameter int NDIG        = 5,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [7:0]               rx_data,
    input  logic                     rx_valid,
    output logic [7:0]               tx_data,
    output logic                     tx_valid,
    input  logic                     tx_ready,
    output logic [N_CH-1:0]          ch_start,
    input  logic [N_CH*DATA_W-1:0]   ch_data,
    input  logic [N_CH-1:0]          ch_valid,
    output logic                     busy,
    output logic                     err_timeout,
    output logic [2:0]               dbg_state
);

    // TX handshake: a byte moves in any cycle where tx_valid and tx_ready are both
    // high; tx_data is held stable while tx_valid is high and tx_ready is low.

    localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int CNT_W = $clog2(TIMEOUT_CYC);
    localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int IDX_W = $clog2(NDIG + 1);
    localparam int BCD_W = 4 * NDIG;

    function automatic bit digits_fit(input int ndig, input int dw);
        longint unsigned p;
        bit              ovf;
        bit              fit;
        p   = 64'd1;
        ovf = 1'b0;
        for (int i = 0; i < ndig; i++) begin
            if (!ovf) begin
                if (p > (64'hFFFF_FFFF_FFFF_FFFF / 64'd10)) ovf = 1'b1;
                else p = p * 64'd10;
            end
        end
        if (ovf)           fit = 1'b1;
        else if (dw >= 64) fit = 1'b0;
        else               fit = (p > ((64'd1 << dw) - 64'd1));
        return fit;
    endfunction

    if (!digits_fit(NDIG, DATA_W)) begin : g_bad_ndig
        $error("NDIG too small to hold the largest DATA_W-bit value");
    end
    if (N_CH < 1 || N_CH > 10) begin : g_bad_nch
        $error("N_CH must be in 1..10");
    end
    if (TIMEOUT_CYC < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYC must be at least 2");
    end

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_START   = 3'd1,
        S_WAIT    = 3'd2,
        S_CONVERT = 3'd3,
        S_SEND    = 3'd4
    } state_t;

    state_t             state_q;
    logic [CH_W-1:0]    ch_sel_q;
    logic [CNT_W-1:0]   wait_cnt_q;
    logic [BIT_W-1:0]   bit_cnt_q;
    logic [DATA_W-1:0]  bin_q;
    logic [BCD_W-1:0]   bcd_q;
    logic [7:0]         reply_q [NDIG+1];
    logic [IDX_W-1:0]   idx_q;
    logic [IDX_W-1:0]   last_q;
    logic [7:0]         tx_data_q;
    logic               tx_valid_q;
    logic [N_CH-1:0]    ch_start_q;
    logic               busy_q;
    logic               err_q;

    logic [DATA_W-1:0]  ch_slice [N_CH];
    logic               sel_valid;
    logic [DATA_W-1:0]  sel_data;
    logic               is_ch;
    logic               is_eol;
    logic [N_CH-1:0]    start_onehot;
    logic [BCD_W-1:0]   bcd_adj;
    logic [BCD_W-1:0]   bcd_d;
    logic [DATA_W-1:0]  bin_d;
    logic [7:0]         digit_ascii [NDIG];
    logic [IDX_W-1:0]   idx_d;

    always_comb begin
        for (int k = 0; k < N_CH; k++) begin
            ch_slice[k] = ch_data[k*DATA_W +: DATA_W];
        end
    end

    assign sel_valid    = ch_valid[ch_sel_q];
    assign sel_data     = ch_slice[ch_sel_q];
    assign is_ch        = (rx_data >= 8'h30) && (rx_data < 8'(8'h30 + N_CH));
    assign is_eol       = (rx_data == 8'h0D) || (rx_data == 8'h0A);
    assign start_onehot = N_CH'(1) << rx_data[3:0];
    assign idx_d        = idx_q + 1'b1;

    // One double-dabble step: add 3 to every nibble >= 5, then shift the binary MSB in.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < NDIG; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
        bcd_d = {bcd_adj[BCD_W-2:0], bin_q[DATA_W-1]};
        bin_d = bin_q << 1;
        for (int i = 0; i < NDIG; i++) begin
            digit_ascii[i] = 8'h30 + {4'h0, bcd_d[4*(NDIG-1-i) +: 4]};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            ch_sel_q   <= '0;
            wait_cnt_q <= '0;
            bit_cnt_q  <= '0;
            bin_q      <= '0;
            bcd_q      <= '0;
            idx_q      <= '0;
            last_q     <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            ch_start_q <= '0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
            for (int i = 0; i <= NDIG; i++) reply_q[i] <= '0;
        end else begin
            ch_start_q <= '0;
            err_q      <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (rx_valid) begin
                        if (is_ch) begin
                            ch_sel_q   <= CH_W'(rx_data[3:0]);
                            ch_start_q <= start_onehot;
                            busy_q     <= 1'b1;
                            state_q    <= S_START;
                        end else if (!is_eol) begin
                            reply_q[0] <= 8'h3F;
                            reply_q[1] <= 8'h0D;
                            last_q     <= IDX_W'(1);
                            idx_q      <= '0;
                            tx_data_q  <= 8'h3F;
                            tx_valid_q <= 1'b1;
                            busy_q     <= 1'b1;
                            state_q    <= S_SEND;
                        end
                    end
                end
                S_START: begin
                    wait_cnt_q <= '0;
                    state_q    <= S_WAIT;
                end
                S_WAIT: begin
                    // A valid in the same cycle as the timeout limit takes priority.
                    if (sel_valid) begin
                        bin_q     <= sel_data;
                        bcd_q     <= '0;
                        bit_cnt_q <= '0;
                        state_q   <= S_CONVERT;
                    end else if (wait_cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                        err_q      <= 1'b1;
                        reply_q[0] <= 8'h45;
                        reply_q[1] <= 8'h0D;
                        last_q     <= IDX_W'(1);
                        idx_q      <= '0;
                        tx_data_q  <= 8'h45;
                        tx_valid_q <= 1'b1;
                        state_q    <= S_SEND;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 1'b1;
                    end
                end
                S_CONVERT: begin
                    bin_q     <= bin_d;
                    bcd_q     <= bcd_d;
                    bit_cnt_q <= bit_cnt_q + 1'b1;
                    if (bit_cnt_q == BIT_W'(DATA_W - 1)) begin
                        for (int i = 0; i < NDIG; i++) reply_q[i] <= digit_ascii[i];
                        reply_q[NDIG] <= 8'h0D;
                        last_q        <= IDX_W'(NDIG);
                        idx_q         <= '0;
                        tx_data_q     <= digit_ascii[0];
                        tx_valid_q    <= 1'b1;
                        state_q       <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (tx_ready) begin
                        if (idx_q == last_q) begin
                            tx_valid_q <= 1'b0;
                            tx_data_q  <= '0;
                            busy_q     <= 1'b0;
                            state_q    <= S_IDLE;
                        end else begin
                            idx_q     <= idx_d;
                            tx_data_q <= reply_q[idx_d];
                        end
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign tx_data     = tx_data_q;
    assign tx_valid    = tx_valid_q;
    assign ch_start    = ch_start_q;
    assign busy        = busy_q;
    assign err_timeout = err_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_sensor_cmd_router.sv
// Self-checking bench for sensor_cmd_router: vector table plus hand-written
// sequences for timeout, backpressure, dropped commands and mid-reply reset.
`timescale 1ns/1ps
module tb_sensor_cmd_router;
  localparam int N_CH = 4;
  localparam int DATA_W = 16;
  localparam int NDIG = 5;
  localparam int TIMEOUT_CYC = 100;

  logic clk;
  logic rst;
  logic [7:0] rx_data;
  logic rx_valid;
  logic [7:0] tx_data;
  logic tx_valid;
  logic tx_ready;
  logic [N_CH-1:0] ch_start;
  logic [N_CH*DATA_W-1:0] ch_data;
  logic [N_CH-1:0] ch_valid;
  logic busy;
  logic err_timeout;
  logic [2:0] dbg_state;

  sensor_cmd_router #(
    .N_CH(N_CH), .DATA_W(DATA_W), .NDIG(NDIG), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk), .rst(rst),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .ch_start(ch_start), .ch_data(ch_data), .ch_valid(ch_valid),
    .busy(busy), .err_timeout(err_timeout), .dbg_state(dbg_state)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard state
  logic [7:0] exp_q[$];
  int vec_cnt = 0;
  int miscompares = 0;
  int pops = 0;
  int ch_start_hi = 0;
  int err_pulses = 0;
  int err_cyc = -1000;
  logic hold_pend = 1'b0;
  logic [7:0] held = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // output monitor: pops the expected queue on every accepted TX byte
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        hold_pend = 1'b0;
        continue;
      end
      if (ch_start != '0) begin
        ch_start_hi++;
        check("ch_start_onehot", 32'($onehot(ch_start)), 32'd1);
      end
      if (err_timeout) begin
        err_pulses++;
        err_cyc = cyc;
      end
      if (hold_pend && tx_valid) check("tx_data_hold", tx_data, held);
      hold_pend = 1'b0;
      if (tx_valid && !tx_ready) begin
        hold_pend = 1'b1;
        held = tx_data;
      end
      if (tx_valid && tx_ready) begin
        pops++;
        if (exp_q.size() == 0) begin
          vec_cnt++;
          miscompares++;
          $display("FAIL tx_unexpected: got byte %0h, none expected (cycle %0d)", tx_data, cyc);
        end else begin
          check("tx_byte", tx_data, exp_q.pop_front());
        end
      end
    end
  end

  // driver tasks
  task automatic push_digits(input logic [15:0] v);
    int tmp;
    logic [7:0] d [NDIG];
    tmp = int'(v);
    for (int i = NDIG - 1; i >= 0; i--) begin
      d[i] = 8'h30 + 8'(tmp % 10);
      tmp = tmp / 10;
    end
    for (int i = 0; i < NDIG; i++) exp_q.push_back(d[i]);
    exp_q.push_back(8'h0D);
  endtask

  task automatic send_cmd(input logic [7:0] b);
    @(posedge clk); #1;
    rx_data = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    rx_data = 8'h00;
  endtask

  // called #1 after a posedge; holds ch_valid[ch] for one cycle
  task automatic pulse_valid(input int ch, input logic [15:0] d);
    ch_data[ch*DATA_W +: DATA_W] = d;
    ch_valid[ch] = 1'b1;
    @(posedge clk); #1;
    ch_valid[ch] = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n;
    n = 0;
    while ((busy || exp_q.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(busy || (exp_q.size() != 0)), 32'd0);
    exp_q.delete();
  endtask

  task automatic wait_pops(input int target, input int budget);
    int n;
    n = 0;
    while (pops < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("pops_reached", 32'(pops >= target), 32'd1);
  endtask

  typedef struct {
    logic [7:0]  cmd;
    int          kind;  // 0 = channel read, 1 = bad command, 2 = ignored byte
    int          ch;
    logic [15:0] data;
  } vec_t;

  vec_t vecs[10];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int lat;
    int start_cyc;
    int p0;
    int n;

    vecs[0] = '{cmd: 8'h32, kind: 0, ch: 2, data: 16'd1234};
    vecs[1] = '{cmd: 8'h31, kind: 0, ch: 1, data: 16'd65535};
    vecs[2] = '{cmd: 8'h30, kind: 0, ch: 0, data: 16'd0};
    vecs[3] = '{cmd: 8'h33, kind: 0, ch: 3, data: 16'($urandom_range(0, 65535))};
    vecs[4] = '{cmd: 8'h58, kind: 1, ch: 0, data: 16'd0};
    vecs[5] = '{cmd: 8'h34, kind: 1, ch: 0, data: 16'd0};
    vecs[6] = '{cmd: 8'h0D, kind: 2, ch: 0, data: 16'd0};
    vecs[7] = '{cmd: 8'h0A, kind: 2, ch: 0, data: 16'd0};
    vecs[8] = '{cmd: 8'h2F, kind: 1, ch: 0, data: 16'd0};
    vecs[9] = '{cmd: 8'h32, kind: 0, ch: 2, data: 16'($urandom_range(0, 65535))};

    rst = 1'b0;
    rx_data = 8'h00;
    rx_valid = 1'b0;
    tx_ready = 1'b1;
    ch_data = '0;
    ch_valid = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tx_data", tx_data, 32'h0);
    check("rst_tx_valid", tx_valid, 32'h0);
    check("rst_ch_start", ch_start, 32'h0);
    check("rst_busy", busy, 32'h0);
    check("rst_err_timeout", err_timeout, 32'h0);
    check("rst_state", dbg_state, 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;

    for (int v = 0; v < 10; v++) begin
      ch_start_hi = 0;
      if (vecs[v].kind == 0) push_digits(vecs[v].data);
      if (vecs[v].kind == 1) begin
        exp_q.push_back(8'h3F);
        exp_q.push_back(8'h0D);
      end
      send_cmd(vecs[v].cmd);
      @(negedge clk);
      check("ch_start_t1", ch_start, (vecs[v].kind == 0) ? (32'd1 << vecs[v].ch) : 32'd0);
      if (vecs[v].kind == 1) check("bad_tx_valid_t1", tx_valid, 32'd1);
      if (vecs[v].kind == 2) check("ignored_busy", busy, 32'd0);
      if (vecs[v].kind == 0) begin
        @(posedge clk); #1;
        @(posedge clk); #1;
        pulse_valid(vecs[v].ch, vecs[v].data);
        lat = 1;
        while (lat < 40) begin
          @(negedge clk);
          if (tx_valid) break;
          @(posedge clk);
          lat++;
        end
        check("first_tx_latency", lat, 32'd17);
      end
      repeat (5) @(posedge clk);
      wait_idle(100, "reply_done");
      check("ch_start_pulses", ch_start_hi, (vecs[v].kind == 0) ? 32'd1 : 32'd0);
    end

    // timeout with a foreign channel's valid asserted during the wait
    ch_start_hi = 0;
    err_pulses = 0;
    err_cyc = -1000;
    exp_q.push_back(8'h45);
    exp_q.push_back(8'h0D);
    send_cmd(8'h31);
    @(negedge clk);
    start_cyc = cyc;
    @(posedge clk); #1;
    ch_data[0 +: DATA_W] = 16'd77;
    ch_valid[0] = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    ch_valid[0] = 1'b0;
    n = 0;
    while (err_pulses == 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check("timeout_cycle", 32'(err_cyc - start_cyc), 32'd101);
    wait_idle(50, "timeout_reply_done");
    check("err_pulse_count", err_pulses, 32'd1);
    check("timeout_ch_start_pulses", ch_start_hi, 32'd1);

    // backpressure mid-reply plus commands dropped while busy
    ch_start_hi = 0;
    push_digits(16'd4321);
    p0 = pops;
    send_cmd(8'h33);
    rx_data = 8'h30;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    pulse_valid(3, 16'd4321);
    wait_pops(p0 + 2, 100);
    @(posedge clk); #1;
    tx_ready = 1'b0;
    rx_data = 8'h30;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    tx_ready = 1'b1;
    wait_idle(100, "bp_reply_done");
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("bp_byte_count", pops - p0, 32'd6);
    check("drop_ch_start_pulses", ch_start_hi, 32'd1);
    check("drop_busy", busy, 32'd0);

    // reset in the middle of a reply, then a clean command
    push_digits(16'd987);
    p0 = pops;
    send_cmd(8'h32);
    @(posedge clk); #1;
    pulse_valid(2, 16'd987);
    wait_pops(p0 + 2, 100);
    #2;
    rst = 1'b0;
    #1;
    check("arst_tx_data", tx_data, 32'h0);
    check("arst_tx_valid", tx_valid, 32'h0);
    check("arst_ch_start", ch_start, 32'h0);
    check("arst_busy", busy, 32'h0);
    check("arst_err_timeout", err_timeout, 32'h0);
    check("arst_state", dbg_state, 32'h0);
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    ch_start_hi = 0;
    push_digits(16'd555);
    p0 = pops;
    send_cmd(8'h33);
    @(negedge clk);
    check("post_rst_ch_start", ch_start, 32'b1000);
    @(posedge clk); #1;
    pulse_valid(3, 16'd555);
    wait_idle(100, "post_rst_reply_done");
    check("post_rst_byte_count", pops - p0, 32'd6);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
    $finish;
  end
endmodule

// File: doc/sensor_cmd_router.md
Name:
sensor_cmd_router

Overview:
- UART-facing command router that serves N_CH generic sensor channels. It replaces the fixed two-sensor crossbar.
- A single ASCII command byte selects a channel. The block pulses that channel's start, waits for its data with a timeout, and converts the DATA_W-bit binary result to NDIG decimal ASCII digits internally using serial double-dabble.
- It streams the digits plus CR to the UART TX path through a valid/ready handshake.
- Adds three behaviours: bad-command reply, timeout reply, and TX backpressure.
- Sits between the UART RX/TX wrappers and the sensor driver blocks.

Parameters:
- N_CH, 4: number of sensor channels, 1..10. Channel k is selected by ASCII '0'+k (8'h30+k).
- DATA_W, 16: width of each channel's result.
- NDIG, 5: decimal digits emitted. Must satisfy 10^NDIG > 2^DATA_W-1; an elaboration-time check is required.
- TIMEOUT_CYC, 1000000: cycles allowed in WAIT before a timeout. Must be ≥ 2.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- rx_data  in  8  received command byte
- rx_valid  in  1  one-cycle strobe; rx_data is valid in this cycle
- tx_data  out  8  byte to UART transmitter
- tx_valid  out  1  tx_data is valid
- tx_ready  in  1  UART transmitter accepts tx_data this cycle
- ch_start  out  N_CH  one-hot, one-cycle start pulse per channel
- ch_data  in  N_CH*DATA_W  channel results; channel k occupies [k*DATA_W +: DATA_W]
- ch_valid  in  N_CH  channel k result valid (level or pulse)
- busy  out  1  high in every state except IDLE
- err_timeout  out  1  one-cycle pulse on timeout

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous, active-low.
- Reset values: tx_data=0, tx_valid=0, ch_start=0, busy=0, err_timeout=0, state=IDLE, all counters and buffers cleared.
- Reset asserted mid-operation aborts immediately. A partially sent reply is not resumed.

States (IDLE, START, WAIT, CONVERT, SEND):
- IDLE:
  - rx_valid with rx_data = 8'h30+k, k<N_CH: latch k, go to START.
  - rx_valid with 8'h0D or 8'h0A: ignored, stay in IDLE.
  - Any other rx_valid byte: load reply "?",CR and go to SEND.
- START: ch_start[k]=1 for exactly one cycle, wait counter cleared, go to WAIT.
- WAIT:
  - ch_valid[k] is sampled from the first WAIT cycle onward. ch_valid from other channels is ignored.
  - When ch_valid[k]=1: capture the channel-k slice of ch_data, go to CONVERT.
  - When the wait counter reaches TIMEOUT_CYC-1 with no valid: err_timeout=1 for one cycle, load "E",CR, go to SEND.
  - If valid and the timeout limit land in the same cycle, valid wins and no error is raised.
- CONVERT:
  - Exactly DATA_W cycles of shift-add-3 over NDIG BCD nibbles.
  - Then load NDIG ASCII digits, most significant first, with leading zeros ('0'+nibble), followed by CR (8'h0D). Go to SEND.
- SEND:
  - tx_valid=1 with tx_data held stable until tx_ready=1. The transfer occurs in a cycle where both are high.
  - The next byte appears the following cycle, and tx_valid may stay high between bytes.
  - After the CR transfer: tx_valid=0, return to IDLE.

Latency:
- rx_valid at cycle t gives ch_start at cycle t+1.
- Capture at cycle c gives the first tx_valid at cycle c+DATA_W+1.
- A bad command at cycle t gives tx_valid at cycle t+1.

Other rules:
- rx_valid while busy=1: byte dropped, no other effect.
- Reply buffer length: NDIG+1 bytes maximum; the byte index counter wraps only via return to IDLE.

Test Plan:
Bench values: N_CH=4, DATA_W=16, NDIG=5, TIMEOUT_CYC=100.
- Normal read: rx 8'h32, then ch_valid[2]=1 with data 1234 three cycles later, tx_ready=1 → ch_start=4'b0100 for one cycle. TX bytes 30 31 32 33 34 0D. First tx_valid 17 cycles after capture.
- Maximum and zero values: ch1 data 65535 → 36 35 35 33 35 0D. ch0 data 0 → 30 30 30 30 30 0D.
- Bad command and ignored bytes: rx 8'h58 ("X") → TX 3F 0D, ch_start stays 0. rx 8'h34 (channel 4, out of range) → 3F 0D. rx 8'h0D → no reply.
- Timeout: rx 8'h31 and ch_valid never asserted → err_timeout pulse exactly 100 cycles after the WAIT entry cycle, then TX 45 0D. Foreign ch_valid[0] during the wait has no effect.
- Backpressure and drop while busy: tx_ready held low 10 cycles mid-reply → tx_data stable and no byte skipped or repeated. rx 8'h30 while busy → dropped, exactly one reply observed.
- Reset mid-SEND: drop rst after 2 bytes sent → all outputs at their reset values asynchronously. After release, a new 8'h33 command completes a normal reply.
